pairhmm_diag_sched: RTL and testbench

Wavefront scheduler for the diagonal PairHMM array. It takes one read/haplotype length pair, walks the anti-diagonals of the R×H DP matrix in order, and splits each diagonal into chunks of at most NUM_PE cells. Chunks are issued to the PE array over a valid/ready handshake. When the last chunk has been accepted, the block waits for the array pipeline to drain and then pulses `done`. It sits between the job front end and the PE array inside `new_HMM`.

---
 rtl/pairhmm_diag_sched.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_pairhmm_diag_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pairhmm_diag_sched.sv
// -----------------------------------------------------------------------------
// pairhmm_diag_sched
//
// Wavefront scheduler for the diagonal PairHMM PE array. A job is an R x H DP
// matrix. The block walks its anti-diagonals d = 0 .. R+H-2 in order. It cuts
// each diagonal into chunks of at most NUM_PE consecutive read rows and offers
// every chunk to the array over a valid/ready handshake. After the final
// chunk is accepted it idles for PE_LAT drain cycles and then pulses done.
//
// Optional feature macro: PAIRHMM_SCHED_PERF_EN
//   When defined, the block adds the perf_cycles output: a 16-bit saturating
//   count of busy cycles for the most recent job.
//
// Ports
//   sys_clk     in   rising-edge clock
//   sys_rst     in   synchronous active-high reset
//   start       in   job request, looked at only while idle
//   read_len    in   R (1..2^LEN_W-1), sampled with start
//   hap_len     in   H (1..2^LEN_W-1), sampled with start
//   busy        out  job in progress (accepted start .. done cycle)
//   cfg_err     out  one-cycle pulse: start seen with R=0 or H=0
//   diag_valid  out  chunk descriptor valid
//   diag_ready  in   PE array accepts the chunk
//   diag_idx    out  anti-diagonal index d
//   row_lo      out  first read row of the chunk
//   row_cnt     out  cells in the chunk (1..NUM_PE)
//   diag_first  out  first chunk of its diagonal
//   diag_last   out  last chunk of the whole job
//   done        out  one-cycle completion pulse
//   perf_cycles out  busy-cycle counter (PAIRHMM_SCHED_PERF_EN only)
// -----------------------------------------------------------------------------
module pairhmm_diag_sched #(
  parameter int LEN_W  = 7,
  parameter int NUM_PE = 8,
  parameter int PE_LAT = 4
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         start,
  input  logic [LEN_W-1:0]             read_len,
  input  logic [LEN_W-1:0]             hap_len,
  output logic                         busy,
  output logic                         cfg_err,
  output logic                         diag_valid,
  input  logic                         diag_ready,
  output logic [LEN_W:0]               diag_idx,
  output logic [LEN_W-1:0]             row_lo,
  output logic [$clog2(NUM_PE+1)-1:0]  row_cnt,
  output logic                         diag_first,
  output logic                         diag_last,
  output logic                         done
`ifdef PAIRHMM_SCHED_PERF_EN
  ,
  output logic [15:0]                  perf_cycles
`endif
);

  localparam int CNT_W = $clog2(NUM_PE + 1);
  // Two extra bits: one for d (which reaches 2^(LEN_W+1)-4) and one for the
  // sign of d-H+1.
  localparam int W2    = LEN_W + 2;
  localparam int FL_W  = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  localparam logic [W2-1:0]   ONE_W    = {{(W2-1){1'b0}}, 1'b1};
  localparam logic [W2-1:0]   TWO_W    = {{(W2-2){1'b0}}, 2'b10};
  localparam logic [W2-1:0]   NUM_PE_W = W2'(NUM_PE);
  localparam logic [FL_W-1:0] FL_LAST  = FL_W'(PE_LAT - 1);
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Highest read row on diagonal d: min(d, R-1).
  function automatic logic [W2-1:0] row_hi_f(input logic [W2-1:0] d,
                                             input logic [W2-1:0] r);
    logic [W2-1:0] r_m1;
    r_m1 = r - ONE_W;
    if (d < r_m1) begin
      row_hi_f = d;
    end else begin
      row_hi_f = r_m1;
    end
  endfunction

  // Lowest read row on diagonal d: max(0, d-H+1). The MSB of the difference
  // acts as its sign bit.
  function automatic logic [W2-1:0] row_lo_f(input logic [W2-1:0] d,
                                             input logic [W2-1:0] h);
    logic [W2-1:0] t;
    t = d - h + ONE_W;
    if (t[W2-1]) begin
      row_lo_f = {W2{1'b0}};
    end else begin
      row_lo_f = t;
    end
  endfunction

  // Chunk size that starts at row lo on a diagonal ending at row hi.
  function automatic logic [W2-1:0] chunk_cnt_f(input logic [W2-1:0] hi,
                                                input logic [W2-1:0] lo);
    logic [W2-1:0] span;
    span = hi - lo + ONE_W;
    if (span > NUM_PE_W) begin
      chunk_cnt_f = NUM_PE_W;
    end else begin
      chunk_cnt_f = span;
    end
  endfunction

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   r_q, r_d;
  logic [LEN_W-1:0]   h_q, h_d;
  logic [LEN_W:0]     diag_idx_q, diag_idx_d;
  logic [LEN_W-1:0]   row_lo_q, row_lo_d;
  logic [CNT_W-1:0]   row_cnt_q, row_cnt_d;
  logic               diag_first_q, diag_first_d;
  logic               diag_last_q, diag_last_d;
  logic               diag_valid_q, diag_valid_d;
  logic               busy_q, busy_d;
  logic               cfg_err_q, cfg_err_d;
  logic               done_q, done_d;
  logic [FL_W-1:0]    flush_cnt_q, flush_cnt_d;

  logic [W2-1:0]      r_w_s, h_w_s, d_w_s, lo_w_s, cnt_w_s;
  logic [W2-1:0]      cur_end_s, last_d_s;
  logic [W2-1:0]      nxt_d_s, nxt_lo_s, nxt_cnt_s;
  logic               nxt_first_s, nxt_last_s;
  logic               start_ok_s;

  assign start_ok_s = start && (read_len != {LEN_W{1'b0}})
                            && (hap_len  != {LEN_W{1'b0}});

  // Descriptor of the chunk that follows the one currently on the outputs.
  always_comb begin
    r_w_s     = {2'b00, r_q};
    h_w_s     = {2'b00, h_q};
    d_w_s     = {1'b0, diag_idx_q};
    lo_w_s    = {2'b00, row_lo_q};
    cnt_w_s   = W2'(row_cnt_q);
    cur_end_s = lo_w_s + cnt_w_s - ONE_W;
    last_d_s  = r_w_s + h_w_s - TWO_W;
    if (cur_end_s == row_hi_f(d_w_s, r_w_s)) begin
      nxt_d_s     = d_w_s + ONE_W;
      nxt_lo_s    = row_lo_f(d_w_s + ONE_W, h_w_s);
      nxt_first_s = 1'b1;
    end else begin
      nxt_d_s     = d_w_s;
      nxt_lo_s    = lo_w_s + NUM_PE_W;
      nxt_first_s = 1'b0;
    end
    nxt_cnt_s  = chunk_cnt_f(row_hi_f(nxt_d_s, r_w_s), nxt_lo_s);
    nxt_last_s = (nxt_d_s == last_d_s) &&
                 ((nxt_lo_s + nxt_cnt_s - ONE_W) == (r_w_s - ONE_W));
  end

  // FSM next state and registered-output next values.
  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    h_d          = h_q;
    diag_idx_d   = diag_idx_q;
    row_lo_d     = row_lo_q;
    row_cnt_d    = row_cnt_q;
    diag_first_d = diag_first_q;
    diag_last_d  = diag_last_q;
    diag_valid_d = diag_valid_q;
    busy_d       = busy_q;
    cfg_err_d    = 1'b0;
    done_d       = 1'b0;
    flush_cnt_d  = flush_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_d      = ST_ISSUE;
          r_d          = read_len;
          h_d          = hap_len;
          diag_idx_d   = {(LEN_W+1){1'b0}};
          row_lo_d     = {LEN_W{1'b0}};
          row_cnt_d    = CNT_W'(1);
          diag_first_d = 1'b1;
          // Diagonal 0 holds a single cell, so it is also the whole job only
          // for a 1x1 matrix.
          diag_last_d  = (read_len == LEN_ONE) && (hap_len == LEN_ONE);
          diag_valid_d = 1'b1;
          busy_d       = 1'b1;
        end else if (start) begin
          cfg_err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (diag_ready) begin
          if (diag_last_q) begin
            state_d      = ST_FLUSH;
            diag_valid_d = 1'b0;
            diag_idx_d   = {(LEN_W+1){1'b0}};
            row_lo_d     = {LEN_W{1'b0}};
            row_cnt_d    = {CNT_W{1'b0}};
            diag_first_d = 1'b0;
            diag_last_d  = 1'b0;
            flush_cnt_d  = {FL_W{1'b0}};
          end else begin
            diag_idx_d   = nxt_d_s[LEN_W:0];
            row_lo_d     = nxt_lo_s[LEN_W-1:0];
            row_cnt_d    = nxt_cnt_s[CNT_W-1:0];
            diag_first_d = nxt_first_s;
            diag_last_d  = nxt_last_s;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FL_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + FL_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d      = ST_IDLE;
        busy_d       = 1'b0;
        diag_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      r_q          <= {LEN_W{1'b0}};
      h_q          <= {LEN_W{1'b0}};
      diag_idx_q   <= {(LEN_W+1){1'b0}};
      row_lo_q     <= {LEN_W{1'b0}};
      row_cnt_q    <= {CNT_W{1'b0}};
      diag_first_q <= 1'b0;
      diag_last_q  <= 1'b0;
      diag_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      done_q       <= 1'b0;
      flush_cnt_q  <= {FL_W{1'b0}};
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      h_q          <= h_d;
      diag_idx_q   <= diag_idx_d;
      row_lo_q     <= row_lo_d;
      row_cnt_q    <= row_cnt_d;
      diag_first_q <= diag_first_d;
      diag_last_q  <= diag_last_d;
      diag_valid_q <= diag_valid_d;
      busy_q       <= busy_d;
      cfg_err_q    <= cfg_err_d;
      done_q       <= done_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign busy       = busy_q;
  assign cfg_err    = cfg_err_q;
  assign diag_valid = diag_valid_q;
  assign diag_idx   = diag_idx_q;
  assign row_lo     = row_lo_q;
  assign row_cnt    = row_cnt_q;
  assign diag_first = diag_first_q;
  assign diag_last  = diag_last_q;
  assign done       = done_q;

`ifdef PAIRHMM_SCHED_PERF_EN
  logic [15:0] perf_q, perf_d;

  // Busy-cycle counter: cleared by an accepted start, saturating otherwise.
  always_comb begin
    perf_d = perf_q;
    if ((state_q == ST_IDLE) && start_ok_s) begin
      perf_d = 16'h0000;
    end else if (busy_q && (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'h0001;
    end else begin
      perf_d = perf_q;
    end
  end

  // Counter register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      perf_q <= 16'h0000;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_pairhmm_diag_sched.sv
// -----------------------------------------------------------------------------
// Self-checking bench for pairhmm_diag_sched. For each job, a reference model
// lists the expected chunk sequence straight from the diagonal/row-range
// rules. The bench then drives the job with full or random diag_ready. It
// checks accepted chunks, stall stability, valid/busy behaviour and done
// timing. It also covers reset, bad lengths and start pulses during a job.
// -----------------------------------------------------------------------------
module tb_pairhmm_diag_sched;

  localparam int LEN_W  = 7;
  localparam int NUM_PE = 8;
  localparam int PE_LAT = 4;
  localparam int CNT_W  = $clog2(NUM_PE + 1);

  logic               sys_clk = 1'b0;
  logic               sys_rst;
  logic               start;
  logic [LEN_W-1:0]   read_len;
  logic [LEN_W-1:0]   hap_len;
  logic               busy;
  logic               cfg_err;
  logic               diag_valid;
  logic               diag_ready;
  logic [LEN_W:0]     diag_idx;
  logic [LEN_W-1:0]   row_lo;
  logic [CNT_W-1:0]   row_cnt;
  logic               diag_first;
  logic               diag_last;
  logic               done;
`ifdef PAIRHMM_SCHED_PERF_EN
  logic [15:0]        perf_cycles;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];

  pairhmm_diag_sched #(.LEN_W(LEN_W), .NUM_PE(NUM_PE), .PE_LAT(PE_LAT)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .start      (start),
    .read_len   (read_len),
    .hap_len    (hap_len),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .diag_valid (diag_valid),
    .diag_ready (diag_ready),
    .diag_idx   (diag_idx),
    .row_lo     (row_lo),
    .row_cnt    (row_cnt),
    .diag_first (diag_first),
    .diag_last  (diag_last),
    .done       (done)
`ifdef PAIRHMM_SCHED_PERF_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Descriptor packing: d[20:13] lo[12:6] cnt[5:2] first[1] last[0].
  function automatic logic [31:0] pack_desc(input int d, input int lo,
                                            input int cnt, input bit first,
                                            input bit last);
    return 32'((d << 13) | (lo << 6) | (cnt << 2) | (int'(first) << 1) | int'(last));
  endfunction

  function automatic logic [31:0] dut_desc();
    return pack_desc(int'(diag_idx), int'(row_lo), int'(row_cnt), diag_first, diag_last);
  endfunction

  // Reference chunk list for an R x H job.
  function automatic void build_model(input int r, input int h);
    exp_q.delete();
    for (int d = 0; d <= r + h - 2; d++) begin
      int lo;
      int hi;
      lo = (d >= h - 1) ? d - h + 1 : 0;
      hi = (d < r - 1) ? d : r - 1;
      for (int row = lo; row <= hi; row += NUM_PE) begin
        int cnt;
        cnt = (hi - row + 1 < NUM_PE) ? hi - row + 1 : NUM_PE;
        exp_q.push_back(pack_desc(d, row, cnt, row == lo, 1'b0));
      end
    end
    exp_q[exp_q.size() - 1] = exp_q[exp_q.size() - 1] | 32'd1;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic run_job(input int r, input int h, input bit rand_ready,
                         input bit poke);
    int          idx;
    int          cyc;
    int          last_acc;
    int          budget;
    bit          got_done;
    bit          prev_stall;
    logic [31:0] prev;
    build_model(r, h);
    budget     = 8 * exp_q.size() + PE_LAT + 100;
    read_len   = LEN_W'(r);
    hap_len    = LEN_W'(h);
    diag_ready = 1'b0;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    cyc        = 1;
    idx        = 0;
    last_acc   = 0;
    got_done   = 1'b0;
    prev_stall = 1'b0;
    prev       = 32'd0;
    while (cyc <= budget) begin
      check_eq($sformatf("busy_c%0d", cyc), 32'(busy), 32'd1);
      check_eq("cfg_err_in_job", 32'(cfg_err), 32'd0);
      if (done) begin
        got_done = 1'b1;
        break;
      end
      check_eq($sformatf("valid_c%0d", cyc), 32'(diag_valid), 32'(idx < exp_q.size()));
      if (prev_stall) check_eq("stall_hold", dut_desc(), prev);
      diag_ready = rand_ready ? ($urandom_range(0, 99) < 60) : 1'b1;
      if (poke) begin
        start    = ($urandom_range(0, 15) == 0);
        read_len = LEN_W'($urandom);
        hap_len  = ($urandom_range(0, 3) == 0) ? '0 : LEN_W'($urandom);
      end
      if (diag_valid) begin
        if (diag_ready) begin
          if (idx < exp_q.size())
            check_eq($sformatf("chunk%0d_r%0d_h%0d", idx, r, h), dut_desc(), exp_q[idx]);
          else
            check_eq("extra_chunk", 32'(idx), 32'(exp_q.size()));
          idx++;
          last_acc = cyc;
        end
        prev_stall = !diag_ready;
        prev       = dut_desc();
      end else begin
        prev_stall = 1'b0;
      end
      tick();
      cyc++;
    end
    start      = 1'b0;
    diag_ready = 1'b0;
    check_eq("done_seen", 32'(got_done), 32'd1);
    check_eq("chunk_count", 32'(idx), 32'(exp_q.size()));
    check_eq("done_cycle", 32'(cyc), 32'(last_acc + PE_LAT + 1));
    if (!rand_ready) check_eq("done_cycle_full", 32'(cyc), 32'(exp_q.size() + PE_LAT + 1));
    tick();
    check_eq("idle_after", 32'({busy, diag_valid, done, cfg_err}), 32'd0);
`ifdef PAIRHMM_SCHED_PERF_EN
    check_eq("perf_cycles", 32'(perf_cycles), 32'(cyc));
`endif
    if (!got_done) begin
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctrl"}, 32'({busy, cfg_err, diag_valid, done}), 32'd0);
    check_eq({tag, "_desc"}, dut_desc(), 32'd0);
  endtask

  initial begin
    sys_rst    = 1'b1;
    start      = 1'b0;
    read_len   = '0;
    hap_len    = '0;
    diag_ready = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
`ifdef PAIRHMM_SCHED_PERF_EN
    check_eq("perf_reset", 32'(perf_cycles), 32'd0);
`endif
    sys_rst = 1'b0;
    tick();

    // Directed jobs with diag_ready held high.
    run_job(1, 1, 1'b0, 1'b0);
    run_job(3, 2, 1'b0, 1'b0);
    run_job(20, 20, 1'b0, 1'b0);
    run_job(127, 127, 1'b0, 1'b0);
    run_job(5, 7, 1'b1, 1'b0);

    // Bad lengths: cfg_err pulse only.
    for (int k = 0; k < 2; k++) begin
      read_len = (k == 0) ? LEN_W'(0) : LEN_W'(9);
      hap_len  = (k == 0) ? LEN_W'(5) : LEN_W'(0);
      start    = 1'b1;
      tick();
      start    = 1'b0;
      check_eq("cfg_err_pulse", 32'(cfg_err), 32'd1);
      check_eq("cfg_err_quiet", 32'({busy, diag_valid, done}), 32'd0);
      tick();
      check_eq("cfg_err_one_cycle", 32'(cfg_err), 32'd0);
      check_eq("cfg_err_idle", 32'({busy, diag_valid, done}), 32'd0);
    end

    // Reset while a chunk is stalled.
    read_len   = LEN_W'(5);
    hap_len    = LEN_W'(7);
    diag_ready = 1'b0;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    tick();
    tick();
    check_eq("stalled_valid", 32'(diag_valid), 32'd1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check_all_zero("mid_reset");
`ifdef PAIRHMM_SCHED_PERF_EN
    check_eq("perf_mid_reset", 32'(perf_cycles), 32'd0);
`endif
    run_job(5, 7, 1'b0, 1'b0);

    // Random jobs with random stalls and stray start pulses.
    for (int j = 0; j < 6; j++) begin
      run_job($urandom_range(1, 127), $urandom_range(1, 127), 1'b1, 1'b1);
    end
    run_job($urandom_range(1, 16), $urandom_range(1, 16), 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
